wind_axis_seq: RTL and testbench
================================

// Module: wind_axis_seq
// PURPOSE
//  Sequencer for the wind speed core. Runs alternating measurement bursts on the X axis (rx1/rx3)
//  and the Y axis (rx2/rx4). For each burst it flushes the core, strobes NSAMP ADC samples into it
//  at a divided rate, waits for the core's ready, and stores the result per axis.
//  Sits between the 4-channel ADC front end and one shared wind core instance.
// PARAMETERS
//  SDIV      8     clocks per sample strobe (>=2)
//  NSAMP     256   samples fed to the core per axis burst (>=1)
//  FLUSH_CYC 2     cycles core_reset is held high before each burst (>=1)
//  TIMEOUT   4096  max cycles waiting for core_ready after the last sample
// PORTS
//  clock        in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  enable       in   1   run continuous X/Y measurements while high
//  meanlen      in   4   averaging length; latched on IDLE->FLUSH, forwarded to the core
//  adc_rx       in   48  {rx4,rx3,rx2,rx1}, each 12 bit, continuously valid
//  core_reset   out  1   reset to the wind core
//  core_enable  out  1   enable to the wind core
//  core_sample  out  1   sample strobe to the wind core
//  core_rxA     out  12  first receiver to the core (rx1 for X, rx2 for Y)
//  core_rxB     out  12  second receiver to the core (rx3 for X, rx4 for Y)
//  core_meanlen out  4   latched meanlen
//  core_speed   in   16  core result
//  core_ready   in   1   core result valid
//  speed_x      out  16  last X result
//  speed_y      out  16  last Y result
//  meas_valid   out  1   1-cycle pulse when speed_x or speed_y is updated
//  meas_axis    out  1   axis of the latest update (0=X, 1=Y); valid with meas_valid
//  busy         out  1   high in any state except IDLE
//  err_timeout  out  1   sticky flag: core_ready did not arrive within TIMEOUT cycles
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE, axis=X. err_timeout is cleared only by reset.
//  All outputs are registered. State transitions take effect on the clock edge.
//  IDLE:  core_enable=0. If enable=1: latch meanlen, go to FLUSH with the current axis.
//  FLUSH: core_reset=1 and core_enable=1 for exactly FLUSH_CYC cycles; clear div, sample and
//         timeout counters; then go to RUN.
//  RUN:   the div counter counts 0..SDIV-1 and wraps.
//         - On each cycle with div==SDIV-1: core_sample=1 for that one cycle, and core_rxA/core_rxB
//           are updated in that same cycle from the current adc_rx per axis; samp++.
//         - core_rxA/core_rxB hold their value between strobes.
//         - First strobe comes SDIV cycles after RUN entry.
//         - After the NSAMP-th strobe go to DRAIN. A burst lasts NSAMP*SDIV cycles.
//  DRAIN: core_sample=0; core_enable stays 1; the timeout counter increments each cycle.
//         - If core_ready=1 on any cycle after the first DRAIN cycle (ready is ignored on the
//           entry cycle): store core_speed into speed_x (axis X) or speed_y (axis Y).
//           Next cycle: meas_valid=1 and meas_axis=axis.
//         - Else, when the count reaches TIMEOUT: set err_timeout; the speed registers are
//           unchanged and meas_valid is not pulsed.
//         - Either way: toggle axis; go to FLUSH if enable=1, else IDLE.
//  enable falling in FLUSH/RUN: abort on the next edge to IDLE. core_enable and core_sample drop;
//         no store, no pulse; the axis is not toggled, so the same axis restarts later.
//  enable falling in DRAIN: the current wait completes (store or timeout), then go to IDLE.
//  meanlen changes outside IDLE are ignored until the next IDLE->FLUSH.
//  core_ready arriving while in FLUSH or RUN is ignored.
//  Reset mid-operation: return immediately to the reset values; no partial store.
// TESTING
//  1 Reset, enable=1, SDIV=8, NSAMP=4, FLUSH_CYC=2: core_reset high 2 cycles; core_sample pulses
//    at RUN+8/16/24/32; DRAIN is entered after the 4th pulse.
//  2 adc_rx={12'h444,12'h333,12'h222,12'h111}: X burst drives core_rxA=111 and core_rxB=333;
//    the following Y burst drives 222 and 444.
//  3 core_ready=1 with core_speed=16'h1234 on the 3rd DRAIN cycle of X: speed_x=1234,
//    meas_valid pulses once with meas_axis=0, then FLUSH begins for Y.
//  4 core_ready held at 0 with TIMEOUT=16: err_timeout=1 after 16 DRAIN cycles, speed_y
//    unchanged, no meas_valid, next burst is X; err_timeout stays set until reset.
//  5 enable dropped mid-RUN (after 2 strobes): IDLE on the next edge, busy=0, no store;
//    re-enabling restarts the same axis with FLUSH.
//  6 meanlen=6 latched, then changed to 9 mid-RUN: core_meanlen stays 6 until the next
//    IDLE->FLUSH; reset asserted in DRAIN clears every output to 0.

Source files
------------

// File: rtl/wind_axis_seq.sv
// Burst sequencer for the shared wind core: alternates X (rx1/rx3) and Y (rx2/rx4)
// measurement bursts, feeding divided-rate samples and storing each axis result.
module wind_axis_seq #(
  parameter int SDIV      = 8,
  parameter int NSAMP     = 256,
  parameter int FLUSH_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  meanlen,
  input  logic [47:0] adc_rx,
  output logic        core_reset,
  output logic        core_enable,
  output logic        core_sample,
  output logic [11:0] core_rxA,
  output logic [11:0] core_rxB,
  output logic [3:0]  core_meanlen,
  input  logic [15:0] core_speed,
  input  logic        core_ready,
  output logic [15:0] speed_x,
  output logic [15:0] speed_y,
  output logic        meas_valid,
  output logic        meas_axis,
  output logic        busy,
  output logic        err_timeout
);

  localparam int DIV_W = $clog2(SDIV);
  localparam int SMP_W = $clog2(NSAMP + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SDIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(NSAMP - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_RUN, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [FL_W-1:0]    fl_q, fl_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [SMP_W-1:0]   samp_q, samp_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               axis_q, axis_d;
  logic [3:0]         meanlen_q, meanlen_d;
  logic [11:0]        rxa_q, rxa_d, rxb_q, rxb_d;
  logic [15:0]        speed_x_q, speed_x_d, speed_y_q, speed_y_d;
  logic               err_q, err_d;
  logic               meas_valid_q, meas_valid_d;
  logic               meas_axis_q, meas_axis_d;
  logic               core_reset_q, core_reset_d;
  logic               core_enable_q, core_enable_d;
  logic               core_sample_q, core_sample_d;
  logic               done;

  // Outputs are registered from the next-state view so they line up with state_q.
  always_comb begin
    state_d      = state_q;
    fl_d         = fl_q;
    div_d        = div_q;
    samp_d       = samp_q;
    to_d         = to_q;
    axis_d       = axis_q;
    meanlen_d    = meanlen_q;
    rxa_d        = rxa_q;
    rxb_d        = rxb_q;
    speed_x_d    = speed_x_q;
    speed_y_d    = speed_y_q;
    err_d        = err_q;
    meas_valid_d = 1'b0;
    meas_axis_d  = meas_axis_q;
    done         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d   = S_FLUSH;
          fl_d      = '0;
          meanlen_d = meanlen;
        end
      end
      S_FLUSH: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          div_d  = '0;
          samp_d = '0;
          to_d   = '0;
          if (fl_q == FL_LAST) state_d = S_RUN;
          else                 fl_d    = fl_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          samp_d = samp_q + 1'b1;
          if (samp_q == SMP_LAST) begin
            state_d = S_DRAIN;
            to_d    = '0;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DRAIN: begin
        to_d = to_q + 1'b1;
        // The entry cycle may still carry a stale ready from the previous core state.
        if (core_ready && (to_q != '0)) begin
          if (axis_q) speed_y_d = core_speed;
          else        speed_x_d = core_speed;
          meas_valid_d = 1'b1;
          meas_axis_d  = axis_q;
          done         = 1'b1;
        end else if (to_q == TO_LAST) begin
          err_d = 1'b1;
          done  = 1'b1;
        end
        if (done) begin
          axis_d = ~axis_q;
          fl_d   = '0;
          state_d = enable ? S_FLUSH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    core_sample_d = (state_d == S_RUN) && (div_d == DIV_LAST);
    if (core_sample_d) begin
      rxa_d = axis_q ? adc_rx[23:12] : adc_rx[11:0];
      rxb_d = axis_q ? adc_rx[47:36] : adc_rx[35:24];
    end
    core_reset_d  = (state_d == S_FLUSH);
    core_enable_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fl_q          <= '0;
      div_q         <= '0;
      samp_q        <= '0;
      to_q          <= '0;
      axis_q        <= 1'b0;
      meanlen_q     <= '0;
      rxa_q         <= '0;
      rxb_q         <= '0;
      speed_x_q     <= '0;
      speed_y_q     <= '0;
      err_q         <= 1'b0;
      meas_valid_q  <= 1'b0;
      meas_axis_q   <= 1'b0;
      core_reset_q  <= 1'b0;
      core_enable_q <= 1'b0;
      core_sample_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fl_q          <= fl_d;
      div_q         <= div_d;
      samp_q        <= samp_d;
      to_q          <= to_d;
      axis_q        <= axis_d;
      meanlen_q     <= meanlen_d;
      rxa_q         <= rxa_d;
      rxb_q         <= rxb_d;
      speed_x_q     <= speed_x_d;
      speed_y_q     <= speed_y_d;
      err_q         <= err_d;
      meas_valid_q  <= meas_valid_d;
      meas_axis_q   <= meas_axis_d;
      core_reset_q  <= core_reset_d;
      core_enable_q <= core_enable_d;
      core_sample_q <= core_sample_d;
    end
  end

  assign core_reset   = core_reset_q;
  assign core_enable  = core_enable_q;
  assign core_sample  = core_sample_q;
  assign core_rxA     = rxa_q;
  assign core_rxB     = rxb_q;
  assign core_meanlen = meanlen_q;
  assign speed_x      = speed_x_q;
  assign speed_y      = speed_y_q;
  assign meas_valid   = meas_valid_q;
  assign meas_axis    = meas_axis_q;
  assign busy         = core_enable_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_wind_axis_seq.sv
// Scoreboard bench for wind_axis_seq: the bench plays the wind core and checks
// strobe timing, per-axis receiver routing, result storage, timeout, abort and reset.
module tb_wind_axis_seq;

  localparam int SDIV      = 8;
  localparam int NSAMP     = 4;
  localparam int FLUSH_CYC = 2;
  localparam int TIMEOUT   = 16;

  logic        clock = 1'b0;
  logic        reset, enable, core_ready;
  logic [3:0]  meanlen;
  logic [47:0] adc_rx;
  logic [15:0] core_speed;
  logic        core_reset, core_enable, core_sample;
  logic [11:0] core_rxA, core_rxB;
  logic [3:0]  core_meanlen;
  logic [15:0] speed_x, speed_y;
  logic        meas_valid, meas_axis, busy, err_timeout;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_meas = 0;
  int rpos   = 0;
  int len, cnt;

  logic [23:0] sq[$];
  logic [16:0] mq[$];

  wind_axis_seq #(
    .SDIV(SDIV), .NSAMP(NSAMP), .FLUSH_CYC(FLUSH_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .meanlen(meanlen), .adc_rx(adc_rx),
    .core_reset(core_reset), .core_enable(core_enable), .core_sample(core_sample),
    .core_rxA(core_rxA), .core_rxB(core_rxB), .core_meanlen(core_meanlen),
    .core_speed(core_speed), .core_ready(core_ready),
    .speed_x(speed_x), .speed_y(speed_y), .meas_valid(meas_valid), .meas_axis(meas_axis),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock; outputs are examined on the falling edge and events matched to the queues.
  task automatic step();
    logic [23:0] es;
    logic [16:0] em;
    @(negedge clock);
    if (core_sample) begin
      if (sq.size() == 0) chk("spurious_strobe", 32'(core_sample), 0);
      else begin
        es = sq.pop_front();
        chk("core_rxA", 32'(core_rxA), 32'(es[23:12]));
        chk("core_rxB", 32'(core_rxB), 32'(es[11:0]));
      end
    end
    if (meas_valid) begin
      n_meas++;
      if (mq.size() == 0) chk("spurious_meas", 32'(meas_valid), 0);
      else begin
        em = mq.pop_front();
        chk("meas_axis", 32'(meas_axis), 32'(em[16]));
        if (em[16]) chk("speed_y", 32'(speed_y), 32'(em[15:0]));
        else        chk("speed_x", 32'(speed_x), 32'(em[15:0]));
      end
    end
  endtask

  task automatic push_burst(input bit axis);
    logic [23:0] e;
    e = axis ? {12'h222, 12'h444} : {12'h111, 12'h333};
    for (int i = 0; i < NSAMP; i++) sq.push_back(e);
  endtask

  task automatic wait_flush(output int flen);
    int n;
    n = 0;
    while (!core_reset && n < 20) begin step(); n++; end
    chk("flush_seen", 32'(core_reset), 1);
    flen = 0;
    while (core_reset && flen < 20) begin flen++; step(); end
    rpos = 1;
  endtask

  task automatic count_strobes(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      do begin step(); rpos++; end while (!core_sample && rpos < 400);
      chk("strobe_pos", rpos, k * SDIV);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_core_reset"},  32'(core_reset), 0);
    chk({tag, "_core_enable"}, 32'(core_enable), 0);
    chk({tag, "_core_sample"}, 32'(core_sample), 0);
    chk({tag, "_core_rxA"},    32'(core_rxA), 0);
    chk({tag, "_core_rxB"},    32'(core_rxB), 0);
    chk({tag, "_meanlen"},     32'(core_meanlen), 0);
    chk({tag, "_speed_x"},     32'(speed_x), 0);
    chk({tag, "_speed_y"},     32'(speed_y), 0);
    chk({tag, "_meas_valid"},  32'(meas_valid), 0);
    chk({tag, "_meas_axis"},   32'(meas_axis), 0);
    chk({tag, "_busy"},        32'(busy), 0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; meanlen = 4'd0; adc_rx = '0;
    core_speed = '0; core_ready = 1'b0;
    repeat (3) step();
    chk_zero("rst");
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // X burst: flush length, strobe spacing, meanlen hold, ready ignored in RUN
    adc_rx  = {12'h444, 12'h333, 12'h222, 12'h111};
    meanlen = 4'd6;
    push_burst(1'b0);
    enable = 1'b1;
    wait_flush(len);
    chk("flush_len", len, FLUSH_CYC);
    chk("meanlen_latched", 32'(core_meanlen), 6);
    core_ready = 1'b1; core_speed = 16'hBAD0;
    count_strobes(1, 2);
    meanlen = 4'd9;
    count_strobes(3, 3);
    chk("meanlen_hold_run", 32'(core_meanlen), 6);
    core_ready = 1'b0;
    count_strobes(4, 4);
    step();
    chk("drain_sample", 32'(core_sample), 0);
    chk("drain_enable", 32'(core_enable), 1);
    chk("drain_busy", 32'(busy), 1);
    core_ready = 1'b1; core_speed = 16'hDEAD;
    step();
    core_ready = 1'b0;
    step();
    core_ready = 1'b1; core_speed = 16'h1234;
    mq.push_back({1'b0, 16'h1234});
    push_burst(1'b1);
    step();
    core_ready = 1'b0;
    chk("meas_pulse", 32'(meas_valid), 1);
    chk("flush_y_start", 32'(core_reset), 1);
    chk("meanlen_after_drain", 32'(core_meanlen), 6);

    // Y burst ending in timeout
    wait_flush(len);
    chk("flush_len_y", len, FLUSH_CYC);
    chk("meas_once", n_meas, 1);
    count_strobes(1, 4);
    step();
    cnt = 1;
    while (!err_timeout && cnt < 60) begin step(); cnt++; end
    chk("timeout_cycles", cnt, TIMEOUT + 1);
    chk("timeout_speed_y", 32'(speed_y), 0);
    chk("timeout_no_meas", n_meas, 1);
    chk("timeout_next_flush", 32'(core_reset), 1);

    // X burst aborted after two strobes, then restarted on the same axis
    push_burst(1'b0);
    wait_flush(len);
    chk("flush_len_x2", len, FLUSH_CYC);
    count_strobes(1, 2);
    enable = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_enable", 32'(core_enable), 0);
    chk("abort_speed_x", 32'(speed_x), 32'h1234);
    chk("err_sticky", 32'(err_timeout), 1);
    sq.delete();
    push_burst(1'b0);
    step(); step();
    chk("idle_meanlen", 32'(core_meanlen), 6);
    enable = 1'b1;
    wait_flush(len);
    chk("meanlen_relatched", 32'(core_meanlen), 9);
    count_strobes(1, 4);
    step(); step();

    // Reset while draining with a ready pending
    reset = 1'b1; core_ready = 1'b1; core_speed = 16'hBEEF;
    step();
    chk_zero("mid_rst");
    enable = 1'b0; reset = 1'b0; core_ready = 1'b0;
    repeat (4) step();
    chk("final_meas_count", n_meas, 1);
    chk("final_speed_x", 32'(speed_x), 0);
    chk("strobe_q_empty", sq.size(), 0);
    chk("meas_q_empty", mq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
